// File: rtl/stopwatch_counter_pkg.sv
// stopwatch_pkg: shared types and constants for the stopwatch time-keeping stage.
//   mode_t       : operating mode of the stopwatch (RUN, PAUSE, ADJUST)
//   bcd_digit_t  : one 4-bit BCD digit
//   SEC_MAX_DEFAULT / MIN_MAX_DEFAULT : default last values before wrap (decimal 59)
package stopwatch_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSE  = 2'd1,
        ADJUST = 2'd2
    } mode_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int SEC_MAX_DEFAULT = 59;
    localparam int MIN_MAX_DEFAULT = 59;

endpackage

// File: rtl/stopwatch_counter_if.sv
// stopwatch_counter_if: groups the stopwatch control inputs and display outputs.
//   onehz_clk, twohz_clk : divider square waves, synchronous to clk
//   pause_pulse          : single-cycle pause toggle request
//   adj, sel             : adjust-mode level and field select (0 = minutes, 1 = seconds)
//   min_tens..sec_ones   : BCD digits to the display multiplexer
//   paused, adj_min, adj_sec : status flags for the display
// Modports: master drives the controls and observes the outputs, slave is the stopwatch.
interface stopwatch_counter_if;
    import stopwatch_pkg::*;

    logic       onehz_clk;
    logic       twohz_clk;
    logic       pause_pulse;
    logic       adj;
    logic       sel;
    bcd_digit_t min_tens;
    bcd_digit_t min_ones;
    bcd_digit_t sec_tens;
    bcd_digit_t sec_ones;
    logic       paused;
    logic       adj_min;
    logic       adj_sec;

    modport master (
        output onehz_clk, twohz_clk, pause_pulse, adj, sel,
        input  min_tens, min_ones, sec_tens, sec_ones, paused, adj_min, adj_sec
    );

    modport slave (
        input  onehz_clk, twohz_clk, pause_pulse, adj, sel,
        output min_tens, min_ones, sec_tens, sec_ones, paused, adj_min, adj_sec
    );

endinterface

// File: rtl/stopwatch_counter_bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter that counts 00..MAX.
//   clk, rst   : clock and asynchronous active-high reset
//   i_inc      : advance by one count this cycle
//   i_wrap_en  : when at MAX, an increment wraps to 00; otherwise the count holds
//   o_tens, o_ones : registered BCD digits
//   o_at_max   : high while the count equals MAX
// MAX is given in decimal (e.g. 59) and must be a legal two-digit BCD value.
module bcd_mod_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_inc,
    input  logic       i_wrap_en,
    output bcd_digit_t o_tens,
    output bcd_digit_t o_ones,
    output logic       o_at_max
);

    localparam bcd_digit_t MAX_TENS = bcd_digit_t'(MAX / 10);
    localparam bcd_digit_t MAX_ONES = bcd_digit_t'(MAX % 10);

    bcd_digit_t r_tens;
    bcd_digit_t r_ones;

    assign o_tens   = r_tens;
    assign o_ones   = r_ones;
    assign o_at_max = (r_tens == MAX_TENS) && (r_ones == MAX_ONES);

    // The terminal value is checked before the ones rollover so that a MAX
    // whose ones digit is not 9 still wraps (or holds) at the right count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (i_inc) begin
            if (o_at_max) begin
                if (i_wrap_en) begin
                    r_tens <= '0;
                    r_ones <= '0;
                end
            end else if (r_ones == 4'd9) begin
                r_ones <= '0;
                r_tens <= r_tens + 4'd1;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS stopwatch fed by the divider's 1 Hz / 2 Hz waves.
//   clk, rst : 100 MHz clock, asynchronous active-high reset
//   bus      : stopwatch_counter_if.slave (controls in, BCD digits and flags out)
// Parameters SEC_MAX / MIN_MAX set the last value of each field before wrap.
// Optional build macro STOPWATCH_SAT_EN: when defined, running count saturates
// at MIN_MAX:SEC_MAX instead of wrapping to 00:00 (adjust still wraps).
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int SEC_MAX = SEC_MAX_DEFAULT,
    parameter int MIN_MAX = MIN_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    stopwatch_counter_if.slave  bus
);

    logic  r_onehzD;
    logic  r_twohzD;
    logic  r_paused;
    logic  r_adjMin;
    logic  r_adjSec;

    logic  w_secTick;
    logic  w_adjTick;
    mode_t w_mode;
    logic  w_secInc;
    logic  w_minInc;
    logic  w_secWrap;
    logic  w_minWrap;
    logic  w_secAtMax;
    logic  w_minAtMax;

    assign w_secTick = bus.onehz_clk & ~r_onehzD;
    assign w_adjTick = bus.twohz_clk & ~r_twohzD;

    // Mode is decoded from the live adj level and the registered pause flag so
    // that an adj rise coincident with a second tick already blocks the tick,
    // and a pause pulse only affects ticks from the following cycle onward.
    always_comb begin
        w_mode = RUN;
        if (bus.adj) begin
            w_mode = ADJUST;
        end else if (r_paused) begin
            w_mode = PAUSE;
        end
    end

    // Increment and wrap control for both fields. In RUN the minutes advance
    // on a seconds carry; in ADJUST only the selected field moves and both
    // fields wrap independently.
    always_comb begin
        w_secInc  = 1'b0;
        w_minInc  = 1'b0;
        w_secWrap = 1'b1;
        w_minWrap = 1'b1;
        case (w_mode)
            RUN: begin
                w_secInc = w_secTick;
                w_minInc = w_secTick & w_secAtMax;
`ifdef STOPWATCH_SAT_EN
                // At the terminal count both counters hold instead of wrapping.
                w_secWrap = ~w_minAtMax;
                w_minWrap = 1'b0;
`endif
            end
            ADJUST: begin
                w_secInc = w_adjTick & bus.sel;
                w_minInc = w_adjTick & ~bus.sel;
            end
            default: begin
            end
        endcase
    end

    // Edge-detect history, pause toggle and registered adjust indicators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_onehzD <= 1'b0;
            r_twohzD <= 1'b0;
            r_paused <= 1'b0;
            r_adjMin <= 1'b0;
            r_adjSec <= 1'b0;
        end else begin
            r_onehzD <= bus.onehz_clk;
            r_twohzD <= bus.twohz_clk;
            if (bus.pause_pulse) begin
                r_paused <= ~r_paused;
            end
            r_adjMin <= bus.adj & ~bus.sel;
            r_adjSec <= bus.adj & bus.sel;
        end
    end

    bcd_mod_counter #(.MAX(SEC_MAX)) u_secCounter (
        .clk       (clk),
        .rst       (rst),
        .i_inc     (w_secInc),
        .i_wrap_en (w_secWrap),
        .o_tens    (bus.sec_tens),
        .o_ones    (bus.sec_ones),
        .o_at_max  (w_secAtMax)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_minCounter (
        .clk       (clk),
        .rst       (rst),
        .i_inc     (w_minInc),
        .i_wrap_en (w_minWrap),
        .o_tens    (bus.min_tens),
        .o_ones    (bus.min_ones),
        .o_at_max  (w_minAtMax)
    );

    assign bus.paused  = r_paused;
    assign bus.adj_min = r_adjMin;
    assign bus.adj_sec = r_adjSec;

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Stopwatch time-keeping stage that sits directly downstream of the clock divider. It consumes the divider's 1 Hz and 2 Hz square waves as single-cycle ticks in the 100 MHz `clk` domain. It maintains an MM:SS count as four BCD digits, supports pause toggling and a manual adjust mode, and feeds the digits to the seven-segment display multiplexer.

## Interface
- `SEC_MAX`, default 59: last seconds value before wrap; must be a legal 2-digit BCD value.
- `MIN_MAX`, default 59: last minutes value before wrap; must be a legal 2-digit BCD value.
- `clk` in 1: 100 MHz system clock.
- `rst` in 1: asynchronous, active-high reset.
- `onehz_clk` in 1: 1 Hz square wave from the divider, synchronous to `clk`.
- `twohz_clk` in 1: 2 Hz square wave from the divider, synchronous to `clk`.
- `pause_pulse` in 1: single-cycle pulse from the debouncer; toggles pause.
- `adj` in 1: level; 1 = adjust mode.
- `sel` in 1: level; adjust field select, 0 = minutes, 1 = seconds.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` out 4 each: BCD digits, registered.
- `paused` out 1: registered pause flag.
- `adj_min`, `adj_sec` out 1 each: registered; high while that field is being adjusted. The display uses these to gate blinking.

## Operation
- Edge detect: `onehz_clk` and `twohz_clk` are each registered once, giving `*_d`.
  - `sec_tick = onehz_clk & ~onehz_d`
  - `adj_tick = twohz_clk & ~twohz_d`
- No synchronizer is used; the inputs are already in the `clk` domain.
- Mode FSM, 3 states, re-evaluated every cycle:
  - ADJUST when `adj=1`.
  - Otherwise PAUSE when `paused=1`.
  - Otherwise RUN.
- `paused` toggles on every `pause_pulse`, in any mode. Leaving ADJUST returns to RUN or PAUSE according to the current `paused` value.
- RUN, on `sec_tick`:
  - Seconds increment.
  - At `SEC_MAX`, seconds go to 00 and minutes increment.
  - At `MIN_MAX:SEC_MAX`, the count wraps to 00:00 (see Configuration).
- PAUSE: digits hold; ticks are ignored.
- ADJUST, on `adj_tick`:
  - The selected field increments and wraps independently: `SEC_MAX`→00 with no carry, `MIN_MAX`→00.
  - The unselected field holds.
  - `sec_tick` is ignored.
- Outputs in ADJUST: `adj_min = adj & ~sel` and `adj_sec = adj & sel`, both registered. Both are 0 outside ADJUST.
- BCD increment: ones digit 9→0 with tens +1. Digit values above 9 never occur. Each tick adds exactly one count.

## Timing
- Reset values: all digits 0, `paused=0`, `adj_min=adj_sec=0`, `onehz_d=twohz_d=0`, state RUN.
- Latency: digits update on the first `clk` edge after the edge at which the `onehz_clk` or `twohz_clk` rise becomes visible, i.e. 1 cycle.
- `adj_min`/`adj_sec` follow `adj`/`sel` with 1-cycle latency.
- `pause_pulse` coincident with `sec_tick`: the tick is applied using the pre-toggle `paused`. A pause pulse arriving while running still takes the tick; one arriving while paused does not.
- `adj` rising coincident with `sec_tick`: ADJUST takes precedence and the tick is dropped.
- `sel` change mid-adjust: takes effect on the next `adj_tick`. No partial increment occurs.
- `rst` mid-count or mid-adjust: outputs clear immediately (asynchronously). The first tick after deassertion counts from 00:00.
- `onehz_clk` high at reset release: no spurious tick unless a rising edge follows `*_d=0` capture. The bench must hold the divider in the same reset.

## Configuration
- `STOPWATCH_SAT_EN`:
  - Defined: in RUN, the count saturates at `MIN_MAX:SEC_MAX` and holds until reset or adjust. ADJUST still wraps each field.
  - Undefined: RUN wraps to 00:00.
- Ports are identical in both builds.

## Structure
- `stopwatch_pkg` holds:
  - the mode enum `{RUN, PAUSE, ADJUST}`;
  - the BCD digit typedef (4 bits);
  - default `SEC_MAX`/`MIN_MAX` constants.
- Sub-module `bcd_mod_counter`: 2-digit BCD counter.
  - Inputs: `inc`, `wrap_en`, `MAX` parameter.
  - Outputs: `tens`, `ones`, `at_max`.
  - Instantiated twice, once for seconds and once for minutes. The top level holds the edge detectors, FSM, carry and saturate logic.

## Test plan
- Reset, then 61 `onehz_clk` rising edges in RUN → 01:01, `paused=0`.
- Preload 59:58 via adjust, release `adj`, 3 `sec_tick`s → 00:01 without the macro; 59:59 with `STOPWATCH_SAT_EN`.
- Count to 00:05, `pause_pulse`, 10 `sec_tick`s → holds 00:05, `paused=1`. A second pulse, then 2 ticks → 00:07.
- `adj=1, sel=1` at 00:58, 3 `twohz_clk` rises → 00:01 with minutes unchanged and `adj_sec=1`, `adj_min=0`. Then `sel=0`, 2 rises → 02:01.
- `pause_pulse` coincident with `sec_tick` while running at 00:10 → 00:11 and `paused=1`. `adj` rising coincident with `sec_tick` → digits unchanged.
- Assert `rst` for 1 cycle at 12:34 during ADJUST → 00:00 immediately, `adj_min=adj_sec=0`, `paused=0`.
